// File: rtl/arbiter_types.sv
// Shared types for the CPU/DMA memory bus arbiter.
package arbiter_types;

   typedef enum logic [2:0] {
      ArbCpu,
      ArbHandover,
      ArbDma,
      ArbCpuForced,
      ArbStateEndMarker
   } arb_state_t;

   typedef enum logic {
      MemOwnerCpu,
      MemOwnerDma
   } mem_owner_t;

endpackage

// File: rtl/dma_burst_counter.sv
// Counts DMA beats within one burst; flags the final allowed beat.
module dma_burst_counter #(
   parameter int unsigned DMA_MAX_BURST = 4
) (
   input  logic clk_in,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic last
);

   localparam int unsigned CW = $clog2(DMA_MAX_BURST + 1);
   localparam logic [CW-1:0] LAST_VAL = CW'(DMA_MAX_BURST - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   assign last = (count_q == LAST_VAL);

   // Saturates at the last beat so the count can never wrap.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (inc && !last) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the memory bus between the 6502 core and a DMA requester,
// granting bounded DMA bursts and never splitting a CPU write.
module mem_bus_arbiter
   import arbiter_types::*;
#(
   parameter int unsigned DMA_MAX_BURST = 4
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic [15:0] cpu_address_in,
   input  logic        cpu_read_write_in,
   input  logic [7:0]  cpu_data_in,
   output logic [7:0]  cpu_data_out,
   output logic        cpu_rdy,
   input  logic        dma_req,
   input  logic [15:0] dma_address,
   input  logic        dma_read_write,
   input  logic [7:0]  dma_wdata,
   output logic        dma_gnt,
   output logic [7:0]  dma_rdata,
   output logic [15:0] mem_address,
   output logic        mem_read_write,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata
);

   if (DMA_MAX_BURST == 0 || DMA_MAX_BURST > 255) begin : g_bad_burst
      $error("DMA_MAX_BURST must be in 1..255");
   end

   arb_state_t state_q;
   arb_state_t state_d;
   mem_owner_t owner;
   logic       cnt_clear;
   logic       cnt_inc;
   logic       cnt_last;

   dma_burst_counter #(
      .DMA_MAX_BURST(DMA_MAX_BURST)
   ) u_cnt (
      .clk_in(clk_in),
      .reset (reset),
      .clear (cnt_clear),
      .inc   (cnt_inc),
      .last  (cnt_last)
   );

   assign cpu_data_out = mem_rdata;
   assign dma_rdata    = mem_rdata;
   assign owner = (state_q == ArbDma) ? MemOwnerDma : MemOwnerCpu;

   always_comb begin
      mem_address    = cpu_address_in;
      mem_read_write = cpu_read_write_in;
      mem_wdata      = cpu_data_in;
      if (owner == MemOwnerDma) begin
         mem_address    = dma_address;
         mem_wdata      = dma_wdata;
         mem_read_write = dma_read_write | ~dma_req;
      end
   end

   always_comb begin
      state_d   = state_q;
      cpu_rdy   = 1'b1;
      dma_gnt   = 1'b0;
      cnt_clear = 1'b0;
      cnt_inc   = 1'b0;
      case (state_q)
         ArbCpu: begin
            // Only leave on a read so a write cycle is never cut.
            if (dma_req && cpu_read_write_in) begin
               state_d = ArbHandover;
            end
         end
         ArbHandover: begin
            cpu_rdy = 1'b0;
            state_d = dma_req ? ArbDma : ArbCpu;
         end
         ArbDma: begin
            cpu_rdy = 1'b0;
            dma_gnt = dma_req;
            if (!dma_req) begin
               state_d   = ArbCpu;
               cnt_clear = 1'b1;
            end else if (cnt_last) begin
               state_d   = ArbCpuForced;
               cnt_clear = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         ArbCpuForced: begin
            state_d = ArbCpu;
         end
         default: begin
            state_d = ArbCpu;
         end
      endcase
   end

   // The handover cycle is a dead read at the stalled CPU address.
   always_comb begin : unused_guard
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q <= ArbCpu;
      end else begin
         state_q <= state_d;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with burst limits of 4 and 1.
module tb_mem_bus_arbiter;

   logic        clk_in = 1'b0;
   logic        reset;
   logic [15:0] cpu_address_in;
   logic        cpu_read_write_in;
   logic [7:0]  cpu_data_in;
   logic        dma_req;
   logic [15:0] dma_address;
   logic        dma_read_write;
   logic [7:0]  dma_wdata;
   logic [7:0]  mem_rdata;

   logic [7:0]  a_cpu_dout, b_cpu_dout;
   logic        a_rdy, b_rdy;
   logic        a_gnt, b_gnt;
   logic [7:0]  a_drd, b_drd;
   logic [15:0] a_addr, b_addr;
   logic        a_rw, b_rw;
   logic [7:0]  a_wd, b_wd;

   int checks = 0;
   int errors = 0;

   always #5 clk_in = ~clk_in;

   mem_bus_arbiter #(.DMA_MAX_BURST(4)) dut4 (
      .clk_in(clk_in), .reset(reset),
      .cpu_address_in(cpu_address_in),
      .cpu_read_write_in(cpu_read_write_in),
      .cpu_data_in(cpu_data_in), .cpu_data_out(a_cpu_dout),
      .cpu_rdy(a_rdy), .dma_req(dma_req),
      .dma_address(dma_address), .dma_read_write(dma_read_write),
      .dma_wdata(dma_wdata), .dma_gnt(a_gnt), .dma_rdata(a_drd),
      .mem_address(a_addr), .mem_read_write(a_rw),
      .mem_wdata(a_wd), .mem_rdata(mem_rdata)
   );

   mem_bus_arbiter #(.DMA_MAX_BURST(1)) dut1 (
      .clk_in(clk_in), .reset(reset),
      .cpu_address_in(cpu_address_in),
      .cpu_read_write_in(cpu_read_write_in),
      .cpu_data_in(cpu_data_in), .cpu_data_out(b_cpu_dout),
      .cpu_rdy(b_rdy), .dma_req(dma_req),
      .dma_address(dma_address), .dma_read_write(dma_read_write),
      .dma_wdata(dma_wdata), .dma_gnt(b_gnt), .dma_rdata(b_drd),
      .mem_address(b_addr), .mem_read_write(b_rw),
      .mem_wdata(b_wd), .mem_rdata(mem_rdata)
   );

   task automatic cyc();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle(input int n);
      cyc();
      dma_req = 1'b0;
      repeat (n) cyc();
   endtask

   task automatic test_reset();
      int n;
      reset = 1'b0;
      cpu_address_in = 16'h4321;
      cpu_read_write_in = 1'b1;
      #3;
      checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL rst_rdy got %b exp 1", a_rdy); end
      checks++; if (a_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt got %b exp 0", a_gnt); end
      checks++; if (a_addr !== 16'h4321) begin errors++; $display("FAIL rst_addr got %h exp 4321", a_addr); end
      checks++; if (b_rdy !== 1'b1) begin errors++; $display("FAIL rst_rdy1 got %b exp 1", b_rdy); end
      cyc();
      reset = 1'b1;
      dma_address = 16'h8000;
      dma_read_write = 1'b1;
      dma_req = 1'b1;
      repeat (4) cyc();
      checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL midburst_gnt got %b exp 1", a_gnt); end
      reset = 1'b0;
      #1;
      checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL async_rdy got %b exp 1", a_rdy); end
      checks++; if (a_gnt !== 1'b0) begin errors++; $display("FAIL async_gnt got %b exp 0", a_gnt); end
      checks++; if (a_addr !== 16'h4321) begin errors++; $display("FAIL async_addr got %h exp 4321", a_addr); end
      checks++; if (a_rw !== 1'b1) begin errors++; $display("FAIL async_rw got %b exp 1", a_rw); end
      cyc();
      reset = 1'b1;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_in);
         if (a_gnt === 1'b1) n++;
         cyc();
      end
      checks++; if (n != 4) begin errors++; $display("FAIL post_rst_burst got %0d exp 4", n); end
      idle(3);
   endtask

   task automatic test_read_handover();
      cpu_address_in = 16'h1234;
      cpu_read_write_in = 1'b1;
      mem_rdata = 8'h5A;
      dma_address = 16'h8000;
      dma_read_write = 1'b1;
      dma_req = 1'b1;
      @(negedge clk_in);
      checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL rd_c0_rdy got %b exp 1", a_rdy); end
      cyc();
      @(negedge clk_in);
      checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL rd_c1_rdy got %b exp 0", a_rdy); end
      checks++; if (a_addr !== 16'h1234) begin errors++; $display("FAIL rd_c1_addr got %h exp 1234", a_addr); end
      checks++; if (a_rw !== 1'b1) begin errors++; $display("FAIL rd_c1_rw got %b exp 1", a_rw); end
      checks++; if (a_gnt !== 1'b0) begin errors++; $display("FAIL rd_c1_gnt got %b exp 0", a_gnt); end
      cyc();
      @(negedge clk_in);
      checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL rd_c2_gnt got %b exp 1", a_gnt); end
      checks++; if (a_addr !== 16'h8000) begin errors++; $display("FAIL rd_c2_addr got %h exp 8000", a_addr); end
      checks++; if (a_drd !== 8'h5A) begin errors++; $display("FAIL rd_c2_rdata got %h exp 5a", a_drd); end
      checks++; if (a_cpu_dout !== 8'h5A) begin errors++; $display("FAIL rd_c2_cpudata got %h exp 5a", a_cpu_dout); end
      checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL rd_c2_rdy got %b exp 0", a_rdy); end
      idle(3);
   endtask

   task automatic test_cpu_write();
      cpu_address_in = 16'h0200;
      cpu_read_write_in = 1'b0;
      cpu_data_in = 8'h77;
      dma_address = 16'h9000;
      dma_read_write = 1'b0;
      dma_wdata = 8'hAB;
      dma_req = 1'b1;
      @(negedge clk_in);
      checks++; if (a_addr !== 16'h0200) begin errors++; $display("FAIL wr_addr got %h exp 0200", a_addr); end
      checks++; if (a_rw !== 1'b0) begin errors++; $display("FAIL wr_rw got %b exp 0", a_rw); end
      checks++; if (a_wd !== 8'h77) begin errors++; $display("FAIL wr_data got %h exp 77", a_wd); end
      checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL wr_rdy got %b exp 1", a_rdy); end
      cyc();
      cpu_address_in = 16'h0201;
      cpu_read_write_in = 1'b1;
      @(negedge clk_in);
      checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL wr_c1_rdy got %b exp 1", a_rdy); end
      cyc();
      @(negedge clk_in);
      checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL wr_c2_rdy got %b exp 0", a_rdy); end
      checks++; if (a_rw !== 1'b1) begin errors++; $display("FAIL wr_c2_rw got %b exp 1", a_rw); end
      checks++; if (a_addr !== 16'h0201) begin errors++; $display("FAIL wr_c2_addr got %h exp 0201", a_addr); end
      cyc();
      @(negedge clk_in);
      checks++; if (a_gnt !== 1'b1) begin errors++; $display("FAIL wr_c3_gnt got %b exp 1", a_gnt); end
      checks++; if (a_rw !== 1'b0) begin errors++; $display("FAIL wr_c3_rw got %b exp 0", a_rw); end
      checks++; if (a_wd !== 8'hAB) begin errors++; $display("FAIL wr_c3_data got %h exp ab", a_wd); end
      checks++; if (a_addr !== 16'h9000) begin errors++; $display("FAIL wr_c3_addr got %h exp 9000", a_addr); end
      idle(3);
   endtask

   task automatic test_burst();
      logic [11:0] eg;
      logic [11:0] er;
      int k;
      eg = 12'b0110_0011_1100;
      er = 12'b0000_1100_0001;
      k = 0;
      cpu_address_in = 16'h0300;
      cpu_read_write_in = 1'b1;
      dma_address = 16'hA000;
      dma_read_write = 1'b0;
      dma_wdata = 8'h00;
      dma_req = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (i == 11) dma_req = 1'b0;
         @(negedge clk_in);
         checks++; if (a_gnt !== eg[i]) begin errors++; $display("FAIL burst_gnt c%0d got %b exp %b", i, a_gnt, eg[i]); end
         checks++; if (a_rdy !== er[i]) begin errors++; $display("FAIL burst_rdy c%0d got %b exp %b", i, a_rdy, er[i]); end
         if (i == 6) begin
            checks++; if (a_addr !== 16'h0300) begin errors++; $display("FAIL burst_forced_addr got %h exp 0300", a_addr); end
         end
         if (eg[i]) begin
            checks++; if (a_wd !== 8'(k)) begin errors++; $display("FAIL burst_wdata c%0d got %h exp %h", i, a_wd, 8'(k)); end
            k++;
         end
         cyc();
         if (eg[i]) dma_wdata = 8'(k);
      end
      idle(3);
   endtask

   task automatic test_drop_handover();
      cpu_address_in = 16'h0400;
      cpu_read_write_in = 1'b1;
      dma_read_write = 1'b1;
      dma_req = 1'b1;
      @(negedge clk_in);
      checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL drop_c0_rdy got %b exp 1", a_rdy); end
      cyc();
      dma_req = 1'b0;
      @(negedge clk_in);
      checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL drop_c1_rdy got %b exp 0", a_rdy); end
      checks++; if (a_gnt !== 1'b0) begin errors++; $display("FAIL drop_c1_gnt got %b exp 0", a_gnt); end
      cyc();
      @(negedge clk_in);
      checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL drop_c2_rdy got %b exp 1", a_rdy); end
      checks++; if (a_gnt !== 1'b0) begin errors++; $display("FAIL drop_c2_gnt got %b exp 0", a_gnt); end
      checks++; if (a_addr !== 16'h0400) begin errors++; $display("FAIL drop_c2_addr got %h exp 0400", a_addr); end
      idle(3);
   endtask

   task automatic test_max1();
      logic [8:0] eg;
      logic [8:0] er;
      eg = 9'b0_0100_0100;
      er = 9'b1_1001_1001;
      cpu_address_in = 16'h0500;
      cpu_read_write_in = 1'b1;
      dma_address = 16'hB000;
      dma_read_write = 1'b1;
      dma_req = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk_in);
         checks++; if (b_gnt !== eg[i]) begin errors++; $display("FAIL max1_gnt c%0d got %b exp %b", i, b_gnt, eg[i]); end
         checks++; if (b_rdy !== er[i]) begin errors++; $display("FAIL max1_rdy c%0d got %b exp %b", i, b_rdy, er[i]); end
         if (i == 3) begin
            checks++; if (b_addr !== 16'h0500) begin errors++; $display("FAIL max1_forced_addr got %h exp 0500", b_addr); end
         end
         cyc();
      end
      idle(3);
   endtask

   initial begin
      reset = 1'b0;
      cpu_address_in = '0;
      cpu_read_write_in = 1'b1;
      cpu_data_in = '0;
      dma_req = 1'b0;
      dma_address = '0;
      dma_read_write = 1'b1;
      dma_wdata = '0;
      mem_rdata = '0;
      test_reset();
      test_read_handover();
      test_cpu_write();
      test_burst();
      test_drop_handover();
      test_max1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
